mmio_io_ctrl: RTL and testbench
===============================

Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O controller on the CPU data bus, directly downstream of the CPU's mem_addr/mem_cmd/write-data outputs.
- Replaces the combinational LED/switch decode with registered peripherals:
  - LED output register
  - synchronized switch input with sticky edge capture
  - prescaled 16-bit timer with compare match and interrupt
- Drives read data plus a hit strobe; the top level muxes this against RAM dout.

Parameters:
- PRESCALE, 4, timer advances once every PRESCALE clk cycles (legal 1..256)
- SW_W, 10, number of switch inputs
- LED_W, 10, number of LED outputs

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (low = reset asserted)
- mem_addr  in  9  CPU bus address
- mem_cmd  in  2  bus command: 2'b00 none, 2'b01 write, 2'b10 read
- wdata  in  16  CPU write data
- sw  in  SW_W  raw asynchronous switch inputs
- read_data  out  16  read data; 16'h0000 when rd_hit=0
- rd_hit  out  1  high when mem_cmd=read and mem_addr matches a register below
- led  out  LED_W  LED register contents
- timer_irq  out  1  match_flag AND ctrl.irq_en

Behaviour:
- Register map (9-bit addresses):
  - 0x100 LED: R/W, bits [LED_W-1:0]
  - 0x140 SW: RO, synchronized switches, zero-extended
  - 0x141 SW_EDGE: sticky rising-edge flags, write-1-to-clear (W1C)
  - 0x180 T_COUNT: R/W
  - 0x181 T_CMP: R/W
  - 0x182 T_CTRL: bit0 enable, bit1 auto_clear, bit2 irq_en; other bits read 0
  - 0x183 T_STAT: bit0 match_flag, W1C
  - Unmapped addresses: no effect, rd_hit=0.
- Reset (reset low, asynchronous): all registers, the sync flops, the prescaler and the flags clear to 0. So led=0, read_data=0, rd_hit=0, timer_irq=0.
- Reads are combinational: read_data and rd_hit are valid in the same cycle as mem_cmd=read. Reads have no side effects.
- Writes take effect on the rising clk edge while mem_cmd=write and the address hits.
- Switch path:
  - 2-flop synchronizer; the SW register returns the second flop.
  - A third flop holds the previous value; a rising edge sets the matching SW_EDGE bit.
  - A W1C write and a new edge on the same bit in the same cycle: the set wins.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1 and generates a one-cycle tick at terminal count.
  - Cleared and held at 0 while enable=0. PRESCALE=1 gives a tick every cycle.
- Timer on a tick:
  - If count==cmp: match_flag<=1; count<=0 if auto_clear, otherwise count+1.
  - Otherwise count<=count+1.
  - Wrap 0xFFFF->0x0000 with no flag.
- Simultaneous events:
  - A CPU write to T_COUNT in a tick cycle wins over the increment; no match is evaluated that cycle.
  - A T_STAT W1C in the same cycle as a match set leaves match_flag=1.
  - A write to T_CMP takes effect for the next tick.
- Asserting reset mid-count clears everything immediately. Deassertion is synchronous to the next edge by use; no in-block reset synchronizer.

Decomposition:
- Shared package:
  - mem_cmd encodings (MNONE, MWRITE, MREAD)
  - the seven register addresses
  - T_CTRL bit indices
  - Used by the CPU and the top-level decode as well.
- One sub-module: sw_sync_edge. Holds the parameterized-width 2-flop synchronizer and the previous-value flop, and outputs sync value and rise pulses.
- The timer and bus decode stay inline.

Test Plan:
- Reset/LED:
  - Hold reset low with sw=10'h3FF -> led=0, read_data=0, rd_hit=0, timer_irq=0.
  - Release reset; write 16'h02A5 to 0x100 -> led=10'h2A5 next edge; a read of 0x100 returns 16'h02A5 with rd_hit=1.
- Switch sync/edge:
  - Drive sw=10'h005 -> reading 0x140 returns 0x0005 from the 2nd edge after the change.
  - SW_EDGE=0x0005.
  - Write 0x0001 to 0x141 -> SW_EDGE=0x0004.
- Timer periodic (PRESCALE=4):
  - cmp=3, ctrl=3'b111 -> count sequence 0,1,2,3,0 with 4 cycles per step.
  - match_flag and timer_irq go high on the 3->0 tick.
  - W1C 0x183 clears them.
- Wrap/free-run:
  - Write count=0xFFFE, cmp=0x0010, ctrl=3'b001 -> count 0xFFFF then 0x0000; match_flag stays 0.
  - match_flag sets when count goes 0x0010->0x0011.
- Collisions:
  - Write T_COUNT=0x0100 in a tick cycle -> count=0x0100, not +1.
  - W1C T_STAT in a match cycle -> match_flag stays 1.
- Decode negative: read 0x0FF and 0x184, and write 0x1FF -> rd_hit=0, read_data=0, no register changes.

Source files
------------

// File: rtl/mmio_io_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O block.
// Holds the bus command encodings, the register addresses and the T_CTRL
// bit positions. The CPU and the top-level address decode import these too.
package mmio_io_ctrl_pkg;

   typedef enum logic [1:0] {
      MNONE  = 2'b00,
      MWRITE = 2'b01,
      MREAD  = 2'b10
   } mem_cmd_e;

   localparam logic [8:0] ADDR_LED     = 9'h100;
   localparam logic [8:0] ADDR_SW      = 9'h140;
   localparam logic [8:0] ADDR_SW_EDGE = 9'h141;
   localparam logic [8:0] ADDR_T_COUNT = 9'h180;
   localparam logic [8:0] ADDR_T_CMP   = 9'h181;
   localparam logic [8:0] ADDR_T_CTRL  = 9'h182;
   localparam logic [8:0] ADDR_T_STAT  = 9'h183;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_AUTO_CLR = 1;
   localparam int CTRL_IRQ_EN   = 2;

endpackage

// File: rtl/mmio_io_ctrl_sw_sync_edge.sv
// Switch input conditioning.
// Two-flop synchronizer followed by a previous-value flop; a rise pulse is
// produced for one cycle on every 0->1 transition of the synchronized value.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   sw      - raw asynchronous switch inputs
//   sw_sync - synchronized switch value (second flop)
//   sw_rise - one-cycle rising-edge pulses, one bit per switch
module sw_sync_edge #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] sw,
   output logic [W-1:0] sw_sync,
   output logic [W-1:0] sw_rise
);

   logic [W-1:0] sync_1;
   logic [W-1:0] sync_2;
   logic [W-1:0] sync_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1    <= '0;
         sync_2    <= '0;
         sync_prev <= '0;
      end else begin
         sync_1    <= sw;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
      end
   end

   assign sw_sync = sync_2;
   assign sw_rise = sync_2 & ~sync_prev;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller on the CPU data bus.
// Registered LED output, synchronized switches with sticky edge flags, and a
// prescaled 16-bit timer with compare match and interrupt.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   mem_addr  - CPU bus address (9 bits)
//   mem_cmd   - bus command (none / write / read)
//   wdata     - CPU write data
//   sw        - raw switch inputs
//   read_data - combinational read data, zero when rd_hit is low
//   rd_hit    - a read is addressing one of this block's registers
//   led       - LED register
//   timer_irq - match flag gated by irq enable
module mmio_io_ctrl
   import mmio_io_ctrl_pkg::*;
#(
   parameter int PRESCALE = 4,
   parameter int SW_W     = 10,
   parameter int LED_W    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [8:0]       mem_addr,
   input  logic [1:0]       mem_cmd,
   input  logic [15:0]      wdata,
   input  logic [SW_W-1:0]  sw,
   output logic [15:0]      read_data,
   output logic             rd_hit,
   output logic [LED_W-1:0] led,
   output logic             timer_irq
);

   localparam logic [7:0] PSC_TC = 8'(PRESCALE - 1);

   logic [LED_W-1:0] led_q;
   logic [SW_W-1:0]  sw_sync;
   logic [SW_W-1:0]  sw_rise;
   logic [SW_W-1:0]  sw_edge;
   logic [SW_W-1:0]  sw_edge_clr;
   logic [15:0]      t_count;
   logic [15:0]      t_cmp;
   logic [2:0]       t_ctrl;
   logic             match_flag;
   logic [7:0]       psc;
   logic             tick;
   logic             match;
   logic             set_flag;
   logic             wr;
   logic             we_led, we_swe, we_cnt, we_cmp, we_ctrl, we_stat;

   sw_sync_edge #(.W(SW_W)) u_sw_sync_edge (
      .clk     (clk),
      .reset   (reset),
      .sw      (sw),
      .sw_sync (sw_sync),
      .sw_rise (sw_rise)
   );

   assign wr      = (mem_cmd == MWRITE);
   assign we_led  = wr && (mem_addr == ADDR_LED);
   assign we_swe  = wr && (mem_addr == ADDR_SW_EDGE);
   assign we_cnt  = wr && (mem_addr == ADDR_T_COUNT);
   assign we_cmp  = wr && (mem_addr == ADDR_T_CMP);
   assign we_ctrl = wr && (mem_addr == ADDR_T_CTRL);
   assign we_stat = wr && (mem_addr == ADDR_T_STAT);

   assign tick  = t_ctrl[CTRL_EN] && (psc == PSC_TC);
   assign match = (t_count == t_cmp);
   // A CPU write to the count owns that cycle, so no match is evaluated.
   assign set_flag    = tick && !we_cnt && match;
   assign sw_edge_clr = we_swe ? wdata[SW_W-1:0] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q      <= '0;
         sw_edge    <= '0;
         t_count    <= '0;
         t_cmp      <= '0;
         t_ctrl     <= '0;
         match_flag <= 1'b0;
         psc        <= '0;
      end else begin
         if (we_led)  led_q  <= wdata[LED_W-1:0];
         if (we_cmp)  t_cmp  <= wdata;
         if (we_ctrl) t_ctrl <= wdata[2:0];

         // New edges are OR-ed in after the clear so a same-cycle set wins.
         sw_edge <= (sw_edge & ~sw_edge_clr) | sw_rise;

         if (!t_ctrl[CTRL_EN] || tick) psc <= '0;
         else                          psc <= psc + 8'd1;

         if (we_cnt)
            t_count <= wdata;
         else if (tick)
            t_count <= (match && t_ctrl[CTRL_AUTO_CLR]) ? 16'h0000 : t_count + 16'd1;

         match_flag <= set_flag | (match_flag & ~(we_stat & wdata[0]));
      end
   end

   always_comb begin
      read_data = 16'h0000;
      rd_hit    = 1'b0;
      if (mem_cmd == MREAD) begin
         rd_hit = 1'b1;
         case (mem_addr)
            ADDR_LED:     read_data = 16'(led_q);
            ADDR_SW:      read_data = 16'(sw_sync);
            ADDR_SW_EDGE: read_data = 16'(sw_edge);
            ADDR_T_COUNT: read_data = t_count;
            ADDR_T_CMP:   read_data = t_cmp;
            ADDR_T_CTRL:  read_data = {13'h0000, t_ctrl};
            ADDR_T_STAT:  read_data = {15'h0000, match_flag};
            default:      rd_hit    = 1'b0;
         endcase
      end
   end

   assign led       = led_q;
   assign timer_irq = match_flag & t_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl. Inputs change and outputs are checked on
// the falling edge; each task call spans a known number of rising edges.
module tb_mmio_io_ctrl;
   import mmio_io_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  mem_addr;
   logic [1:0]  mem_cmd;
   logic [15:0] wdata;
   logic [9:0]  sw;
   logic [15:0] read_data;
   logic        rd_hit;
   logic [9:0]  led;
   logic        timer_irq;

   int n_cmp = 0;
   int n_err = 0;

   mmio_io_ctrl #(.PRESCALE(4), .SW_W(10), .LED_W(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_addr  (mem_addr),
      .mem_cmd   (mem_cmd),
      .wdata     (wdata),
      .sw        (sw),
      .read_data (read_data),
      .rd_hit    (rd_hit),
      .led       (led),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One rising edge with the write on the bus.
   task automatic wr(input logic [8:0] a, input logic [15:0] d);
      mem_addr = a;
      mem_cmd  = MWRITE;
      wdata    = d;
      @(negedge clk);
      mem_cmd  = MNONE;
      mem_addr = 9'h000;
      wdata    = 16'h0000;
   endtask

   // Combinational read inside the low phase; no clock edge consumed.
   task automatic rd(input logic [8:0] a, input logic [15:0] exp, input logic exp_hit,
                     input string tag);
      mem_addr = a;
      mem_cmd  = MREAD;
      #1;
      chk({tag, ".data"}, read_data, exp);
      chk({tag, ".hit"}, {15'h0000, rd_hit}, {15'h0000, exp_hit});
      mem_cmd  = MNONE;
      mem_addr = 9'h000;
   endtask

   initial begin
      reset    = 1'b0;
      sw       = 10'h3FF;
      mem_addr = 9'h000;
      mem_cmd  = MNONE;
      wdata    = 16'h0000;
      #3;
      chk("rst_led",  {6'h00, led}, 16'h0000);
      chk("rst_rdat", read_data, 16'h0000);
      chk("rst_hit",  {15'h0000, rd_hit}, 16'h0000);
      chk("rst_irq",  {15'h0000, timer_irq}, 16'h0000);
      sw = 10'h000;
      step(2);
      reset = 1'b1;
      step(1);

      // LED register
      wr(ADDR_LED, 16'h02A5);
      chk("led_out", {6'h00, led}, 16'h02A5);
      rd(ADDR_LED, 16'h02A5, 1'b1, "led_rd");

      // Switch synchronizer and edge flags
      sw = 10'h005;
      step(1);
      rd(ADDR_SW, 16'h0000, 1'b1, "sw_1edge");
      step(1);
      rd(ADDR_SW, 16'h0005, 1'b1, "sw_2edge");
      step(1);
      rd(ADDR_SW_EDGE, 16'h0005, 1'b1, "swe_set");
      wr(ADDR_SW_EDGE, 16'h0001);
      rd(ADDR_SW_EDGE, 16'h0004, 1'b1, "swe_w1c");
      sw = 10'h007;
      step(2);
      wr(ADDR_SW_EDGE, 16'h0002);  // clear lands on the same edge as bit1 rise
      rd(ADDR_SW_EDGE, 16'h0006, 1'b1, "swe_setwins");

      // Periodic timer, auto-clear, irq enabled
      wr(ADDR_T_CMP, 16'h0003);
      wr(ADDR_T_CTRL, 16'h0007);
      rd(ADDR_T_CTRL, 16'h0007, 1'b1, "ctrl_rd");
      step(3);
      rd(ADDR_T_COUNT, 16'h0000, 1'b1, "per_c0");
      step(1);
      rd(ADDR_T_COUNT, 16'h0001, 1'b1, "per_c1");
      step(4);
      rd(ADDR_T_COUNT, 16'h0002, 1'b1, "per_c2");
      step(4);
      rd(ADDR_T_COUNT, 16'h0003, 1'b1, "per_c3");
      chk("per_irq_lo", {15'h0000, timer_irq}, 16'h0000);
      step(4);
      rd(ADDR_T_COUNT, 16'h0000, 1'b1, "per_wrap0");
      rd(ADDR_T_STAT, 16'h0001, 1'b1, "per_flag");
      chk("per_irq_hi", {15'h0000, timer_irq}, 16'h0001);
      wr(ADDR_T_STAT, 16'h0001);
      rd(ADDR_T_STAT, 16'h0000, 1'b1, "per_w1c");
      chk("per_irq_clr", {15'h0000, timer_irq}, 16'h0000);
      step(14);
      wr(ADDR_T_STAT, 16'h0001);   // W1C on the match edge
      rd(ADDR_T_STAT, 16'h0001, 1'b1, "stat_setwins");
      rd(ADDR_T_COUNT, 16'h0000, 1'b1, "stat_cnt");
      wr(ADDR_T_CTRL, 16'h0000);
      wr(ADDR_T_STAT, 16'h0001);
      rd(ADDR_T_STAT, 16'h0000, 1'b1, "stat_clr2");

      // Free-run wrap, no auto-clear, no irq
      wr(ADDR_T_COUNT, 16'hFFFE);
      wr(ADDR_T_CMP, 16'h0010);
      wr(ADDR_T_CTRL, 16'h0001);
      step(4);
      rd(ADDR_T_COUNT, 16'hFFFF, 1'b1, "fr_ffff");
      step(4);
      rd(ADDR_T_COUNT, 16'h0000, 1'b1, "fr_0000");
      rd(ADDR_T_STAT, 16'h0000, 1'b1, "fr_noflag");
      step(64);
      rd(ADDR_T_COUNT, 16'h0010, 1'b1, "fr_10");
      rd(ADDR_T_STAT, 16'h0000, 1'b1, "fr_flag_lo");
      step(4);
      rd(ADDR_T_COUNT, 16'h0011, 1'b1, "fr_11");
      rd(ADDR_T_STAT, 16'h0001, 1'b1, "fr_flag_hi");
      chk("fr_irq_off", {15'h0000, timer_irq}, 16'h0000);

      // Count write on a tick edge wins over the increment
      step(3);
      wr(ADDR_T_COUNT, 16'h0100);
      rd(ADDR_T_COUNT, 16'h0100, 1'b1, "cw_win");
      step(4);
      rd(ADDR_T_COUNT, 16'h0101, 1'b1, "cw_next");

      // Decode negatives
      wr(ADDR_T_CTRL, 16'hFFF8);
      rd(ADDR_T_CTRL, 16'h0000, 1'b1, "ctrl_mask");
      rd(9'h0FF, 16'h0000, 1'b0, "un_0ff");
      rd(9'h184, 16'h0000, 1'b0, "un_184");
      wr(9'h1FF, 16'hFFFF);
      rd(ADDR_LED, 16'h02A5, 1'b1, "un_led");
      rd(ADDR_T_CMP, 16'h0010, 1'b1, "un_cmp");
      rd(ADDR_T_COUNT, 16'h0101, 1'b1, "un_cnt");

      // Asynchronous reset mid-run
      wr(ADDR_T_CTRL, 16'h0001);
      step(2);
      #1;
      reset = 1'b0;
      #1;
      chk("arst_led", {6'h00, led}, 16'h0000);
      rd(ADDR_T_COUNT, 16'h0000, 1'b1, "arst_cnt");
      rd(ADDR_T_CTRL, 16'h0000, 1'b1, "arst_ctrl");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
